// File: rtl/ccx_ic_arbiter_n_if.sv
// Requestor/responder bundle for the N-port core-complex arbiter.
// master = requestor+responder side driving the arbiter; slave = the arbiter itself.
interface ccx_ic_arbiter_n_if #(
    parameter int NP = 4,
    parameter int AW = 39,
    parameter int DW = 64,
    parameter int SW = DW / 8
);
    logic [NP-1:0]    req_req;
    logic [NP-1:0]    req_gnt;
    logic [NP*AW-1:0] req_addr;
    logic [NP-1:0]    req_wen;
    logic [NP*SW-1:0] req_strb;
    logic [NP*DW-1:0] req_wdata;
    logic [NP-1:0]    req_err;
    logic [DW-1:0]    req_rdata;
    logic             rsp_req;
    logic             rsp_gnt;
    logic [AW-1:0]    rsp_addr;
    logic             rsp_wen;
    logic [SW-1:0]    rsp_strb;
    logic [DW-1:0]    rsp_wdata;
    logic             rsp_err;
    logic [DW-1:0]    rsp_rdata;

    modport master (
        output req_req, req_addr, req_wen, req_strb, req_wdata,
        output rsp_gnt, rsp_err, rsp_rdata,
        input  req_gnt, req_err, req_rdata,
        input  rsp_req, rsp_addr, rsp_wen, rsp_strb, rsp_wdata
    );

    modport slave (
        input  req_req, req_addr, req_wen, req_strb, req_wdata,
        input  rsp_gnt, rsp_err, rsp_rdata,
        output req_gnt, req_err, req_rdata,
        output rsp_req, rsp_addr, rsp_wen, rsp_strb, rsp_wdata
    );
endinterface

// File: rtl/ccx_ic_arbiter_n.sv
// N-requestor to 1-responder arbiter, fixed-priority or round-robin, selection locked while stalled.
// Request path is combinational; responses routed one cycle after a grant via route_q.
module ccx_ic_arbiter_n #(
    parameter int NP = 4,
    parameter int AW = 39,
    parameter int DW = 64,
    parameter int SW = DW / 8,
    parameter bit RR = 1'b1
) (
    input  logic               g_clk,
    input  logic               g_rst,
    ccx_ic_arbiter_n_if.slave  bus
);
    localparam int IW = (NP > 1) ? $clog2(NP) : 1;

    logic          lock_q, lock_d;
    logic [IW-1:0] lock_id_q, lock_id_d;
    logic [IW-1:0] rr_last_q, rr_last_d;
    logic [NP-1:0] route_q, route_d;

    logic          sel_vld;
    logic [IW-1:0] sel;

    // A locked port whose request vanished falls through to normal arbitration.
    always_comb begin
        sel_vld = 1'b0;
        sel     = '0;
        if (lock_q && bus.req_req[lock_id_q]) begin
            sel_vld = 1'b1;
            sel     = lock_id_q;
        end else if (!RR) begin
            for (int i = NP - 1; i >= 0; i--) begin
                if (bus.req_req[i]) begin
                    sel_vld = 1'b1;
                    sel     = IW'(i);
                end
            end
        end else begin
            // Walk from furthest to nearest so the first port after rr_last_q wins.
            for (int k = NP; k >= 1; k--) begin
                automatic int idx = (int'(rr_last_q) + k) % NP;
                if (bus.req_req[idx]) begin
                    sel_vld = 1'b1;
                    sel     = IW'(idx);
                end
            end
        end
    end

    always_comb begin
        bus.rsp_req   = sel_vld;
        bus.rsp_addr  = '0;
        bus.rsp_wen   = 1'b0;
        bus.rsp_strb  = '0;
        bus.rsp_wdata = '0;
        bus.req_gnt   = '0;
        for (int i = 0; i < NP; i++) begin
            if (sel_vld && (sel == IW'(i))) begin
                bus.rsp_addr   = bus.req_addr[i*AW +: AW];
                bus.rsp_wen    = bus.req_wen[i];
                bus.rsp_strb   = bus.req_strb[i*SW +: SW];
                bus.rsp_wdata  = bus.req_wdata[i*DW +: DW];
                bus.req_gnt[i] = bus.rsp_gnt;
            end
        end
        bus.req_err   = route_q & {NP{bus.rsp_err}};
        bus.req_rdata = bus.rsp_rdata;
    end

    always_comb begin
        lock_d    = 1'b0;
        lock_id_d = lock_id_q;
        rr_last_d = rr_last_q;
        route_d   = '0;
        if (sel_vld && !bus.rsp_gnt) begin
            lock_d    = 1'b1;
            lock_id_d = sel;
        end else if (sel_vld && bus.rsp_gnt) begin
            route_d[sel] = 1'b1;
            if (RR) begin
                rr_last_d = sel;
            end
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            rr_last_q <= IW'(NP - 1);
            route_q   <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            rr_last_q <= rr_last_d;
            route_q   <= route_d;
        end
    end
endmodule
